video_timing_gen: RTL
=====================

# video_timing_gen

Parametrised raster timing generator, the successor to the fixed 640x480 sync generator. Produces pixel coordinates, blanking, hsync/vsync and frame/line strobes for any CEA/VESA-style timing. Sync outputs are delayed by a configurable pixel-pipeline latency so they stay aligned with downstream pattern or pixel logic. It sits ahead of the pixel source and the TMDS video encoder in the video path.

## Interface
- CW, 12: width of counters, coordinates and cfg fields
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: default horizontal timing in pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: default vertical timing in lines
- HSYNC_POL, 0 / VSYNC_POL, 0: 1 = sync output high during pulse, 0 = low during pulse
- PIX_LATENCY, 0: extra cycles of delay (0..15) applied to blank/hsync/vsync/de
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- x  out  CW  horizontal counter (hcnt), undelayed
- y  out  CW  vertical counter (vcnt), undelayed
- pos_active  out  1  x<h_active && y<v_active, undelayed
- line_start  out  1  1-cycle pulse when x==0, undelayed
- frame_start  out  1  1-cycle pulse when x==0 && y==0, undelayed
- blank  out  1  delayed, registered blanking
- de  out  1  delayed, registered, equals !blank
- hsync / vsync  out  1  delayed, registered, polarity per parameter
- cfg_* ports: present only with VIDEO_TIMING_PROG_EN; see Configuration

## Operation
- hcnt counts 0..h_total-1, where h_total = h_active+h_fp+h_sync+h_bp. On wrap, vcnt increments, counting 0..v_total-1, then wraps to 0.
- Horizontal sync pulse is active for hcnt in [h_active+h_fp, h_active+h_fp+h_sync). Vertical sync pulse is active for vcnt in [v_active+v_fp, v_active+v_fp+v_sync). Vsync changes with hcnt, not aligned to the hsync edge.
- blank = !(hcnt<h_active && vcnt<v_active).
- All arithmetic is unsigned CW bits. Totals must be at most 2^CW. Comparisons are made against precomputed boundary registers, not adder chains in the count path.
- Delay line: one register stage plus PIX_LATENCY shift stages for {blank, de, hsync, vsync}.

## Timing
- Reset values:
  - x=0, y=0, pos_active=0
  - line_start=0, frame_start=0
  - blank=1, de=0
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL (inactive level)
  - all delay stages hold inactive values
- First cycle after reset release: x=0, y=0, line_start=1, frame_start=1.
- blank, de, hsync and vsync reflect the counter value from PIX_LATENCY+1 cycles earlier.
- A frame lasts exactly h_total*v_total cycles; frame_start recurs at that period.
- Reset asserted mid-frame: the next cycle shows reset values, with no partial pulses retained in the delay line.

## Configuration
- Macro VIDEO_TIMING_PROG_EN, when defined:
  - Adds ports: cfg_valid in 1; cfg_ready out 1; cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp in CW each; cfg_err out 1.
  - Transfer occurs when cfg_valid && cfg_ready. Fields are captured into a shadow register and cfg_ready drops.
  - The shadow becomes active on the cycle counters wrap to (0,0), i.e. the first cycle of the next frame uses the new timing. cfg_ready returns high that same cycle.
  - A transfer with any of h_active, h_sync, v_active or v_sync equal to 0, or with a total exceeding 2^CW, is discarded. cfg_err pulses 1 cycle after capture, cfg_ready stays high, and the active timing is unchanged.
  - Reset loads the parameter defaults, clears the shadow, sets cfg_ready=1 and cfg_err=0.
- Without the macro: no cfg ports; timing is fixed at the parameters.

## Structure
- Package video_pkg holds:
  - typedef video_timing_t: packed struct of the 8 CW-wide fields
  - localparams VT_640X480, VT_800X600, VT_1280X720
  - function vt_total(), used for parameter defaults and the validity check
- One sub-module, video_delay_line (parameters WIDTH, DEPTH, RESET_VAL), implements the synchronous-reset shift register used for the output delay.

## Test plan
- Defaults, PIX_LATENCY=0 -> hsync=0 exactly for x=656..751 sampled 1 cycle later; vsync=0 for y=490..491; frame_start period 420000 cycles; 307200 de cycles per frame.
- PIX_LATENCY=3 -> de rises 4 cycles after x==0 on line y=0, and falls 4 cycles after x==640.
- HSYNC_POL=1, VSYNC_POL=1 -> sync outputs inverted; reset value of both is 0.
- PROG_EN: at y=100 write 800x600 (fp40, sync128, bp88 / fp1, sync4, bp23) -> cfg_ready=0 until the wrap; the next frame has h_total 1056, v_total 628, and cfg_ready returns to 1.
- PROG_EN: write h_sync=0 -> cfg_err 1-cycle pulse, timing unchanged, cfg_ready stays 1.
- Reset asserted at x=300, y=200 for 2 cycles -> outputs at reset values; after release x=0, y=0, frame_start=1, and no stale sync pulse emerges from the delay line.

Source files
------------

// File: rtl/video_pkg.sv
// Shared raster timing types, standard presets and the line/frame total helper.
package video_pkg;

  localparam int VT_W = 12;

  typedef struct packed {
    logic [VT_W-1:0] h_active;
    logic [VT_W-1:0] h_fp;
    logic [VT_W-1:0] h_sync;
    logic [VT_W-1:0] h_bp;
    logic [VT_W-1:0] v_active;
    logic [VT_W-1:0] v_fp;
    logic [VT_W-1:0] v_sync;
    logic [VT_W-1:0] v_bp;
  } video_timing_t;

  localparam video_timing_t VT_640X480 = '{
    VT_W'(640), VT_W'(16), VT_W'(96), VT_W'(48),
    VT_W'(480), VT_W'(10), VT_W'(2), VT_W'(33)
  };
  localparam video_timing_t VT_800X600 = '{
    VT_W'(800), VT_W'(40), VT_W'(128), VT_W'(88),
    VT_W'(600), VT_W'(1), VT_W'(4), VT_W'(23)
  };
  localparam video_timing_t VT_1280X720 = '{
    VT_W'(1280), VT_W'(110), VT_W'(40), VT_W'(220),
    VT_W'(720), VT_W'(5), VT_W'(5), VT_W'(20)
  };

  function automatic int unsigned vt_total(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Synchronous-reset shift register; DEPTH stages, every stage resets to RESET_VAL.
module video_delay_line #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_d[gi] = din;
      end else begin : g_tail
        assign stage_d[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_q[i] <= reset ? RESET_VAL : stage_d[i];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with pipelined blank/de/sync outputs.
// Define VIDEO_TIMING_PROG_EN to add the runtime timing configuration port.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int CW          = 12,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIX_LATENCY = 0
) (
  input  logic          clk,
  input  logic          reset,
`ifdef VIDEO_TIMING_PROG_EN
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_active,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_bp,
  output logic          cfg_err,
`endif
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          pos_active,
  output logic          line_start,
  output logic          frame_start,
  output logic          blank,
  output logic          de,
  output logic          hsync,
  output logic          vsync
);

  // Counters compare only against these precomputed boundaries.
  typedef struct packed {
    logic [CW-1:0] h_act;
    logic [CW-1:0] h_ss;
    logic [CW-1:0] h_se;
    logic [CW-1:0] h_last;
    logic [CW-1:0] v_act;
    logic [CW-1:0] v_ss;
    logic [CW-1:0] v_se;
    logic [CW-1:0] v_last;
  } bounds_t;

  function automatic bounds_t mk_bounds(input int unsigned ha, input int unsigned hf,
                                        input int unsigned hs, input int unsigned hb,
                                        input int unsigned va, input int unsigned vf,
                                        input int unsigned vs, input int unsigned vb);
    bounds_t b;
    b.h_act  = CW'(ha);
    b.h_ss   = CW'(ha + hf);
    b.h_se   = CW'(ha + hf + hs);
    b.h_last = CW'(vt_total(ha, hf, hs, hb) - 1);
    b.v_act  = CW'(va);
    b.v_ss   = CW'(va + vf);
    b.v_se   = CW'(va + vf + vs);
    b.v_last = CW'(vt_total(va, vf, vs, vb) - 1);
    return b;
  endfunction

  localparam bounds_t    BND_DEF   = mk_bounds(H_ACTIVE, H_FP, H_SYNC, H_BP,
                                               V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [3:0] SYNC_IDLE = {1'b1, 1'b0, !HSYNC_POL, !VSYNC_POL};

  bounds_t       bnd;
  logic          run_q, run_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          h_wrap, h_vis, v_vis, hs_on, vs_on;
  logic [3:0]    stage_in, sync_out;

  assign h_wrap = run_q && (hcnt_q == bnd.h_last);

  // run_q holds the counters at (0,0) for the first cycle after reset release.
  always_comb begin
    run_d  = 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (run_q) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + CW'(1);
      if (h_wrap) begin
        vcnt_d = (vcnt_q == bnd.v_last) ? '0 : vcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      run_q  <= run_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // A sync end that wrapped to zero means the pulse runs to the end of the line/frame.
  always_comb begin
    h_vis    = hcnt_q < bnd.h_act;
    v_vis    = vcnt_q < bnd.v_act;
    hs_on    = (hcnt_q >= bnd.h_ss) && ((hcnt_q < bnd.h_se) || (bnd.h_se == '0));
    vs_on    = (vcnt_q >= bnd.v_ss) && ((vcnt_q < bnd.v_se) || (bnd.v_se == '0));
    stage_in = SYNC_IDLE;
    if (run_q) begin
      stage_in = {!(h_vis && v_vis), h_vis && v_vis,
                  hs_on ? HSYNC_POL : !HSYNC_POL,
                  vs_on ? VSYNC_POL : !VSYNC_POL};
    end
  end

  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign pos_active  = run_q && h_vis && v_vis;
  assign line_start  = run_q && (hcnt_q == '0);
  assign frame_start = line_start && (vcnt_q == '0);

  video_delay_line #(
    .WIDTH    (4),
    .DEPTH    (PIX_LATENCY + 1),
    .RESET_VAL(SYNC_IDLE)
  ) u_delay (
    .clk  (clk),
    .reset(reset),
    .din  (stage_in),
    .dout (sync_out)
  );

  assign {blank, de, hsync, vsync} = sync_out;

`ifdef VIDEO_TIMING_PROG_EN
  bounds_t bnd_q, bnd_d, shd_q, shd_d;
  logic    pend_q, pend_d, cfg_ready_q, cfg_ready_d, cfg_err_q, cfg_err_d;
  logic    cfg_ok, frame_wrap;

  assign frame_wrap = h_wrap && (vcnt_q == bnd_q.v_last);

  always_comb begin
    cfg_ok = (cfg_h_active != '0) && (cfg_h_sync != '0) &&
             (cfg_v_active != '0) && (cfg_v_sync != '0) &&
             (vt_total(32'(cfg_h_active), 32'(cfg_h_fp), 32'(cfg_h_sync), 32'(cfg_h_bp))
                <= (32'd1 << CW)) &&
             (vt_total(32'(cfg_v_active), 32'(cfg_v_fp), 32'(cfg_v_sync), 32'(cfg_v_bp))
                <= (32'd1 << CW));
    bnd_d       = bnd_q;
    shd_d       = shd_q;
    pend_d      = pend_q;
    cfg_ready_d = cfg_ready_q;
    cfg_err_d   = 1'b0;
    // A pending shadow can only exist while cfg_ready is low, so these never collide.
    if (frame_wrap && pend_q) begin
      bnd_d       = shd_q;
      pend_d      = 1'b0;
      cfg_ready_d = 1'b1;
    end
    if (cfg_valid && cfg_ready_q) begin
      if (cfg_ok) begin
        shd_d       = mk_bounds(32'(cfg_h_active), 32'(cfg_h_fp), 32'(cfg_h_sync),
                                32'(cfg_h_bp), 32'(cfg_v_active), 32'(cfg_v_fp),
                                32'(cfg_v_sync), 32'(cfg_v_bp));
        pend_d      = 1'b1;
        cfg_ready_d = 1'b0;
      end else begin
        cfg_err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bnd_q       <= BND_DEF;
      shd_q       <= '0;
      pend_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      bnd_q       <= bnd_d;
      shd_q       <= shd_d;
      pend_q      <= pend_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bnd       = bnd_q;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
`else
  assign bnd = BND_DEF;
`endif

endmodule
